// File: rtl/multicycle_chunk_adder.sv
// Sequential adder/subtractor: CHUNK bits per cycle, carry held in a register.
// start/busy/done handshake; Sum/Carry/Overflow update only on completion.
module multicycle_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             busy,
  output logic             done
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Operands shift right each cycle so the active chunk is always the low one
  logic [CHUNK:0] csum;
  logic           cin_msb;

  assign csum = {1'b0, opa_q[CHUNK-1:0]}
              + {1'b0, opb_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};

  assign cin_msb = csum[CHUNK-1] ^ opa_q[CHUNK-1] ^ opb_q[CHUNK-1];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      RUN: begin
        opa_d   = opa_q >> CHUNK;
        opb_d   = opb_q >> CHUNK;
        part_d  = (part_q >> CHUNK)
                | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = csum[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == KLAST) begin
          sum_d   = part_d;
          cout_d  = csum[CHUNK];
          ovf_d   = cin_msb ^ csum[CHUNK];
          k_d     = '0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = sub ? ~Cin : Cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Sum      = sum_q;
  assign Carry    = cout_q;
  assign Overflow = ovf_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Directed bench: 32/8, 8/8 and 8/4 instances, table vectors plus
// handshake corner sequences (mid-run start, back-to-back, async reset).
module tb_multicycle_chunk_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_start, s_sub, s_cin;
  logic [31:0] s_a, s_b, s_sum;
  logic        s_c, s_v, s_busy, s_done;

  logic        p_start, p_sub, p_cin;
  logic [7:0]  p_a, p_b, p_sum;
  logic        p_c, p_v, p_busy, p_done;

  logic        q_start, q_sub, q_cin;
  logic [7:0]  q_a, q_b, q_sum;
  logic        q_c, q_v, q_busy, q_done;

  multicycle_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .reset(reset), .start(s_start), .sub(s_sub),
    .A(s_a), .B(s_b), .Cin(s_cin), .Sum(s_sum), .Carry(s_c),
    .Overflow(s_v), .busy(s_busy), .done(s_done));

  multicycle_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
    .clk(clk), .reset(reset), .start(p_start), .sub(p_sub),
    .A(p_a), .B(p_b), .Cin(p_cin), .Sum(p_sum), .Carry(p_c),
    .Overflow(p_v), .busy(p_busy), .done(p_done));

  multicycle_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .reset(reset), .start(q_start), .sub(q_sub),
    .A(q_a), .B(q_b), .Cin(q_cin), .Sum(q_sum), .Carry(q_c),
    .Overflow(q_v), .busy(q_busy), .done(q_done));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go32(input logic sb, input logic [31:0] a,
                      input logic [31:0] b, input logic ci);
    s_sub   = sb;
    s_a     = a;
    s_b     = b;
    s_cin   = ci;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_a     = $urandom;
    s_b     = $urandom;
    s_cin   = ~ci;
    s_sub   = ~sb;
  endtask

  task automatic wait32(input logic [31:0] hold, output int cyc);
    cyc = 0;
    while (!s_done && cyc < 20) begin
      chk("busy_in_run", s_busy, 1);
      chk("sum_hold", s_sum, hold);
      tick();
      cyc++;
    end
  endtask

  task automatic run_q(input logic sb, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec,
                       input logic ev);
    int cyc;
    q_sub = sb; q_a = a; q_b = b; q_cin = ci; q_start = 1'b1;
    tick();
    q_start = 1'b0;
    q_a = ~a;
    cyc = 0;
    while (!q_done && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("w8c4_latency", cyc, 2);
    chk("w8c4_sum", q_sum, es);
    chk("w8c4_carry", q_c, ec);
    chk("w8c4_ovf", q_v, ev);
  endtask

  logic [31:0] prev;
  int          cyc;

  initial begin
    vt[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[2] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0007, 1'b1, 1'b0};
    vt[4] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[6] = '{1'b0, 32'h00FF_00FF, 32'h0000_FF01, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vt[7] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    reset = 1'b1;
    s_start = 0; s_sub = 0; s_cin = 0; s_a = 0; s_b = 0;
    p_start = 0; p_sub = 0; p_cin = 0; p_a = 0; p_b = 0;
    q_start = 0; q_sub = 0; q_cin = 0; q_a = 0; q_b = 0;
    #12;
    chk("rst_sum", s_sum, 0);
    chk("rst_carry", s_c, 0);
    chk("rst_ovf", s_v, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 8/8: single-cycle latency
    p_a = 8'd200; p_b = 8'd200; p_cin = 1'b1; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    chk("w8c8_busy", p_busy, 1);
    chk("w8c8_nodone", p_done, 0);
    tick();
    chk("w8c8_done", p_done, 1);
    chk("w8c8_sum", p_sum, 8'h91);
    chk("w8c8_carry", p_c, 1);
    chk("w8c8_ovf", p_v, 0);

    // 8/4 subtract
    run_q(1'b1, 8'd5, 8'd220, 1'b0, 8'd41, 1'b0, 1'b0);
    tick();
    run_q(1'b1, 8'd128, 8'd1, 1'b1, 8'd126, 1'b1, 1'b1);

    // 32/8 table
    prev = 32'h0;
    for (int i = 0; i < 9; i++) begin
      go32(vt[i].sub, vt[i].a, vt[i].b, vt[i].cin);
      wait32(prev, cyc);
      chk("latency", cyc, 4);
      chk("done_hi", s_done, 1);
      chk("busy_lo", s_busy, 0);
      chk("sum", s_sum, vt[i].sum);
      chk("carry", s_c, vt[i].c);
      chk("ovf", s_v, vt[i].v);
      prev = vt[i].sum;
      tick();
      chk("done_pulse", s_done, 0);
    end

    // start during RUN is ignored
    go32(1'b0, 32'h0000_1000, 32'h0000_0234, 1'b0);
    tick();
    s_a = 32'hDEAD_BEEF; s_b = 32'h1111_1111; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    wait32(prev, cyc);
    chk("midrun_latency", cyc + 2, 4);
    chk("midrun_sum", s_sum, 32'h0000_1234);
    prev = 32'h0000_1234;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrun_once", s_done, 0);
    end

    // start held high: three operations back to back
    s_sub = 0; s_a = 32'd1; s_b = 32'd2; s_cin = 0; s_start = 1'b1;
    tick();
    s_sub = 1; s_a = 32'd100; s_b = 32'd30; s_cin = 0;
    wait32(prev, cyc);
    chk("b2b1_latency", cyc, 4);
    chk("b2b1_sum", s_sum, 32'd3);
    tick();
    chk("b2b_done_drop", s_done, 0);
    s_sub = 0; s_a = 32'hF000_0000; s_b = 32'h1000_0000; s_cin = 0;
    wait32(32'd3, cyc);
    chk("b2b2_spacing", cyc + 1, 5);
    chk("b2b2_sum", s_sum, 32'd70);
    chk("b2b2_carry", s_c, 1);
    tick();
    s_start = 1'b0;
    wait32(32'd70, cyc);
    chk("b2b3_spacing", cyc + 1, 5);
    chk("b2b3_sum", s_sum, 32'd0);
    chk("b2b3_carry", s_c, 1);
    chk("b2b3_ovf", s_v, 0);
    tick();
    chk("b2b_idle", s_busy, 0);

    // asynchronous reset mid-run
    go32(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    tick();
    chk("pre_rst_sum", s_sum, 32'd0);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", s_busy, 0);
    chk("arst_done", s_done, 0);
    chk("arst_sum", s_sum, 0);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_done", s_done, 0);
    end
    go32(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait32(32'd0, cyc);
    chk("post_rst_latency", cyc, 4);
    chk("post_rst_sum", s_sum, 32'h8000_0000);
    chk("post_rst_carry", s_c, 0);
    chk("post_rst_ovf", s_v, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
